// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared constants for the button front end and the mode controller.
//   Button bit map used on every NUM_BTN-wide button vector, plus the mode
//   encodings the downstream controller drives. No ports.
package ctrl_pkg;

  localparam int NUM_BTN      = 5;
  localparam int BTN_RST      = 0;
  localparam int BTN_ERR      = 1;
  localparam int BTN_PAUSE    = 2;
  localparam int BTN_CONTINUE = 3;
  localparam int BTN_UART     = 4;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  typedef enum logic [2:0] {
    MODE_ERROR = 3'd2,
    MODE_PAUSE = 3'd4,
    MODE_RUN   = 3'd5,
    MODE_UART  = 3'd6
  } mode_e;

endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if -- button bundle between the board pins and the conditioner.
//   btn_raw_i      raw asynchronous buttons (board polarity)
//   btn_level_o    debounced active-high level
//   btn_pulse_o    one-cycle press strobe
//   btn_release_o  one-cycle release strobe
//   master: the board/button source; slave: the conditioner.
interface btn_conditioner_if
  import ctrl_pkg::*;
();

  btn_vec_t btn_raw_i;
  btn_vec_t btn_level_o;
  btn_vec_t btn_pulse_o;
  btn_vec_t btn_release_o;

  modport master (
    output btn_raw_i,
    input  btn_level_o,
    input  btn_pulse_o,
    input  btn_release_o
  );

  modport slave (
    input  btn_raw_i,
    output btn_level_o,
    output btn_pulse_o,
    output btn_release_o
  );

endinterface

// File: rtl/btn_conditioner_cell.sv
// debounce_cell -- one button: 2-flop synchronizer, stability counter,
//   debounced level and press/release strobes.
//   clk_i     system clock, rising edge
//   rst_i     synchronous active-high reset
//   btn       raw button, already converted to active-high
//   level     debounced level
//   pressed   one-cycle strobe in the first cycle level reads 1
//   released  one-cycle strobe in the first cycle level reads 0
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn,
  output logic level,
  output logic pressed,
  output logic released
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The count tops out one short of DEBOUNCE_CYCLES: the cycle that would
  // reach it commits the new level instead, so the counter never wraps.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop here
  // samples the pre-edge value of the others (sync[1] feeds the compare).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Synchronizer clears to the released level, whatever the board polarity.
      sync     <= '0;
      count    <= '0;
      level    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      pressed  <= 1'b0;
      released <= 1'b0;
      if (sync[1] == level) begin
        // Any agreeing sample restarts the stability window (glitch rejection).
        count <= '0;
      end else if (count == CNT_LAST) begin
        level    <= sync[1];
        count    <= '0;
        pressed  <= sync[1];
        released <= ~sync[1];
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner -- debounces and edge-detects the five board buttons.
//   clk_i  system clock (10 MHz), rising edge
//   rst_i  synchronous active-high reset
//   bus    btn_conditioner_if.slave: btn_raw_i in, btn_level_o /
//          btn_pulse_o / btn_release_o out (bit map from ctrl_pkg)
//   DEBOUNCE_CYCLES  stable samples before a level change is accepted (2..2^24)
//   ACTIVE_LOW       1 when board buttons read 0 while pressed
// Bits are independent; simultaneous presses give simultaneous pulses.
module btn_conditioner
  import ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input logic               clk_i,
  input logic               rst_i,
  btn_conditioner_if.slave  bus
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_param
    $error("btn_conditioner: DEBOUNCE_CYCLES out of range 2..2^24");
  end

  btn_vec_t btn_hi;
  btn_vec_t level;
  btn_vec_t pressed;
  btn_vec_t released;

  // Polarity is normalised before the synchronizer so everything downstream
  // is active-high.
  assign btn_hi = ACTIVE_LOW ? ~bus.btn_raw_i : bus.btn_raw_i;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .btn      (btn_hi[i]),
      .level    (level[i]),
      .pressed  (pressed[i]),
      .released (released[i])
    );
  end

  assign bus.btn_level_o   = level;
  assign bus.btn_pulse_o   = pressed;
  assign bus.btn_release_o = released;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner -- self-checking bench for btn_conditioner.
//   Two instances share clock and reset: dut_h (ACTIVE_LOW=0) sees the pressed
//   vector, dut_l (ACTIVE_LOW=1) sees its complement; both must match one
//   behavioural model. Directed cases cover the documented timing scenarios,
//   followed by randomized press/bounce/reset traffic.
module tb_btn_conditioner;
  import ctrl_pkg::*;

  localparam int D = 4;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  btn_vec_t pressed = '0;
  int       cyc = 0;
  int       checks = 0;
  int       errors = 0;
  bit       chk_en = 1'b0;

  // Behavioural model state.
  btn_vec_t m_s1 = '0, m_s2 = '0;
  btn_vec_t m_lvl = '0, m_pulse = '0, m_rel = '0;
  int       run_start [NUM_BTN];
  int       edge_no = 0;

  btn_conditioner_if if_h ();
  btn_conditioner_if if_l ();

  btn_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut_h (
    .clk_i (clk), .rst_i (rst), .bus (if_h)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_l (
    .clk_i (clk), .rst_i (rst), .bus (if_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input btn_vec_t got, input btn_vec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  // Model: raw reaches the decision point two synchronizer stages later; a
  // level changes once D consecutive samples all disagree with it.
  task automatic model_edge();
    btn_vec_t sample;
    sample = m_s2;
    edge_no++;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_rel = '0;
      for (int i = 0; i < NUM_BTN; i++) run_start[i] = -1;
    end else begin
      m_pulse = '0;
      m_rel   = '0;
      m_s2    = m_s1;
      m_s1    = pressed;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sample[i] == m_lvl[i]) begin
          run_start[i] = -1;
        end else begin
          if (run_start[i] < 0) run_start[i] = edge_no;
          if (edge_no - run_start[i] + 1 >= D) begin
            m_lvl[i]     = sample[i];
            m_pulse[i]   = sample[i];
            m_rel[i]     = !sample[i];
            run_start[i] = -1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    if (chk_en) begin
      check("level_h",   if_h.btn_level_o,   m_lvl);
      check("pulse_h",   if_h.btn_pulse_o,   m_pulse);
      check("release_h", if_h.btn_release_o, m_rel);
      check("level_l",   if_l.btn_level_o,   m_lvl);
      check("pulse_l",   if_l.btn_pulse_o,   m_pulse);
      check("release_l", if_l.btn_release_o, m_rel);
    end
  endtask

  // One clock: model advances on the edge, inputs for "edge cyc" are driven
  // just after it, outputs of cycle cyc are compared on the falling edge.
  task automatic cycle(input btn_vec_t v, input bit r);
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    pressed        = v;
    if_h.btn_raw_i = v;
    if_l.btn_raw_i = ~v;
    rst            = r;
    @(negedge clk);
    compare_all();
  endtask

  // Two reset edges; returns with rst released at edge 0.
  task automatic reset_seq(input btn_vec_t v);
    cycle(v, 1'b1);
    cycle(v, 1'b1);
    cycle(v, 1'b0);
    chk_en = 1'b1;
    cyc    = 0;
  endtask

  function automatic btn_vec_t one_at(input int e, input int at, input btn_vec_t v);
    return (e == at) ? v : btn_vec_t'(0);
  endfunction

  initial begin
    btn_vec_t v;
    bit       r;
    for (int i = 0; i < NUM_BTN; i++) run_start[i] = -1;
    if_h.btn_raw_i = '0;
    if_l.btn_raw_i = '1;

    // Clean press on the rst button.
    reset_seq('0);
    for (int e = 1; e <= 20; e++) begin
      cycle((e >= 10) ? btn_vec_t'(5'b00001) : btn_vec_t'(0), 1'b0);
      if (e >= 8) check("clean_pulse", if_h.btn_pulse_o, one_at(e, 16, 5'b00001));
      if (e >= 16) check("clean_level", btn_vec_t'(if_h.btn_level_o[BTN_RST]), 5'd1);
    end

    // Bounce on pause: 1,0,1,0 on edges 10-13, then stable.
    reset_seq('0);
    for (int e = 1; e <= 24; e++) begin
      v = '0;
      if (e == 10 || e == 12 || e >= 14) v[BTN_PAUSE] = 1'b1;
      cycle(v, 1'b0);
      if (e >= 8) check("bounce_pulse", if_h.btn_pulse_o, one_at(e, 20, 5'b00100));
    end

    // Simultaneous press and release of err and uart.
    reset_seq('0);
    for (int e = 1; e <= 40; e++) begin
      cycle((e >= 10 && e < 30) ? btn_vec_t'(5'b10010) : btn_vec_t'(0), 1'b0);
      if (e >= 8) begin
        check("simul_pulse",   if_h.btn_pulse_o,   one_at(e, 16, 5'b10010));
        check("simul_release", if_h.btn_release_o, one_at(e, 36, 5'b10010));
      end
    end

    // Reset mid-count: the count is discarded, the held button re-qualifies.
    reset_seq('0);
    for (int e = 1; e <= 25; e++) begin
      v = (e >= 10) ? btn_vec_t'(5'b00010) : btn_vec_t'(0);
      r = (e == 13 || e == 14);
      cycle(v, r);
      if (e >= 10) begin
        check("rstmid_pulse",   if_h.btn_pulse_o,   one_at(e, 21, 5'b00010));
        check("rstmid_release", if_h.btn_release_o, '0);
      end
    end

    // Button held through reset release counts as a new press.
    reset_seq(5'b01000);
    for (int e = 1; e <= 10; e++) begin
      cycle(5'b01000, 1'b0);
      check("held_pulse", if_h.btn_pulse_o, one_at(e, 6, 5'b01000));
    end

    // Active-low instance: idle all-ones raw is quiet, 11011 presses pause.
    reset_seq('0);
    for (int e = 1; e <= 20; e++) begin
      cycle((e >= 10) ? btn_vec_t'(5'b00100) : btn_vec_t'(0), 1'b0);
      check("al_pulse",   if_l.btn_pulse_o,   one_at(e, 16, 5'b00100));
      check("al_release", if_l.btn_release_o, '0);
    end

    // Randomized traffic: held patterns of varied length with bounce and
    // occasional resets.
    reset_seq('0);
    v = '0;
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      if ($urandom_range(0, 3) == 0) v = btn_vec_t'($urandom);
      else v[$urandom_range(0, NUM_BTN - 1)] ^= 1'b1;
      len = $urandom_range(1, D + 4);
      r   = ($urandom_range(0, 40) == 0);
      for (int k = 0; k < len; k++) cycle(v, r && (k < 2));
    end
    cycle('0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 200000, stable-sample count before a level change is accepted (20 ms at 10 MHz); legal range 2..2^24.
REQ-002 Parameter ACTIVE_LOW, default 0, 1 = raw board buttons read 0 when pressed.
REQ-003 clk_i  input  1  system clock (10 MHz core clock), all logic on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 btn_raw_i  input  5  asynchronous board buttons; bit map [0] rst, [1] err, [2] pause, [3] continue, [4] uart.
REQ-006 btn_level_o  output  5  debounced, active-high, registered button level, same bit map.
REQ-007 btn_pulse_o  output  5  one-clock active-high press strobe per bit, feeding the mode controller's btn_*_i inputs.
REQ-008 btn_release_o  output  5  one-clock active-high release strobe per bit.

Function
REQ-009 Each raw bit SHALL be inverted when ACTIVE_LOW=1, then passed through a 2-flop synchronizer; no other logic sees btn_raw_i.
REQ-010 Each bit SHALL hold a counter of width clog2(DEBOUNCE_CYCLES+1), cleared in any cycle where the synchronized sample equals btn_level_o.
REQ-011 When sample differs from level, the counter SHALL increment; on the cycle it would reach DEBOUNCE_CYCLES, level SHALL take the sample value and the counter SHALL clear.
REQ-012 A single cycle of sample equal to level during counting SHALL restart the count from 0 (glitch rejection).
REQ-013 btn_pulse_o[i] SHALL be 1 for exactly the one cycle in which btn_level_o[i] first reads 1; btn_release_o[i] likewise for the first cycle it reads 0.
REQ-014 Latency: raw press stable from edge N SHALL give btn_level_o/btn_pulse_o high in cycle N+2+DEBOUNCE_CYCLES.
REQ-015 Holding a button SHALL NOT produce further pulses; the next pulse requires an accepted release first.
REQ-016 Bits SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses (priority is resolved downstream, not here).
REQ-017 Counters SHALL saturate-free never exceed DEBOUNCE_CYCLES; no wrap-around is reachable.
REQ-018 Pulse and release on the same bit in the same cycle SHALL be impossible.

Reset
REQ-019 While rst_i=1: synchronizer flops, counters, btn_level_o, btn_pulse_o, btn_release_o SHALL all be 0 next edge (synchronizer reset value is the de-asserted logical level, independent of ACTIVE_LOW).
REQ-020 Button held through reset release SHALL be treated as a new press: one pulse at cycle 2+DEBOUNCE_CYCLES after the first non-reset edge.
REQ-021 rst_i asserted mid-count SHALL discard the count; no pulse or release strobe SHALL leak out in the reset cycle or the cycle after.

Structure
REQ-022 Shared package ctrl_pkg SHALL hold BTN_RST=0, BTN_ERR=1, BTN_PAUSE=2, BTN_CONTINUE=3, BTN_UART=4, NUM_BTN=5, and the mode encodings 2 error, 4 pause, 5 run, 6 uart.
REQ-023 One sub-module debounce_cell (1-bit: synchronizer, counter, level, strobes) SHALL be instantiated NUM_BTN times by generate; top holds only polarity inversion and wiring.

Verification (bench uses DEBOUNCE_CYCLES=4, ACTIVE_LOW=0)
REQ-024 Clean press: btn_raw_i=5'b00001 from edge 10 -> btn_pulse_o=5'b00001 in cycle 16 only, btn_level_o[0]=1 from 16.
REQ-025 Bounce: raw[2] toggles 1,0,1,0 on edges 10-13 then stable 1 -> no pulse before cycle 20; single pulse on bit 2 in cycle 20.
REQ-026 Simultaneous: raw=5'b10010 at edge 10 -> pulse=5'b10010 in cycle 16; release at edge 30 -> release=5'b10010 in cycle 36, pulse stays 0.
REQ-027 Reset mid-count: raw[1]=1 at edge 10, rst_i=1 at edges 13-14 -> no strobe in 10-16; pulse[1] in cycle 21.
REQ-028 ACTIVE_LOW=1 rerun: raw=5'b11111 idle gives no strobes after reset; raw=5'b11011 at edge 10 -> pulse=5'b00100 in cycle 16.
